// File: rtl/bus_arb_pkg.sv
// Shared FSM encoding and index/decode helpers for bus_arb_mux and its driver decode.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    // Turnaround counter covers 0..7 idle cycles.
    localparam int CNT_W = $clog2(8);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic onehot_bit(input int idx, input int pos);
        return (idx == pos);
    endfunction

endpackage

// File: rtl/tristate_driver_w.sv
// W-bit tristate driver onto a shared bus; purely combinational, no flow control.
module tristate_driver_w #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output tri   [W-1:0] bus_o
);

    assign bus_o = en ? din : {W{1'bz}};

endmodule

// File: rtl/bus_arb_mux.sv
// Round-robin arbiter muxing N requesters over a shared tristate bus into a valid/ready register; BUS_ARB_LOCK_EN adds multi-beat lock.
// Latency: gnt one cycle after req in IDLE, dout valid the edge after gnt; at most one beat per 2+TURNAROUND cycles.
// Backpressure: while dout is full and out_ready is low the owner is held with gnt low.
module bus_arb_mux
    import bus_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int TURNAROUND = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
`ifdef BUS_ARB_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   dout,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int IW = idx_w(N);

    state_e            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      dout_q, dout_d;
    logic              out_valid_q, out_valid_d;

    logic [N-1:0]      oh;
    logic [N-1:0]      en;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic              found;
    logic              can_load;
    logic              own_req;
    logic              xfer;
    logic              hold;
    tri   [W-1:0]      bus;

`ifdef BUS_ARB_LOCK_EN
    assign hold = lock[owner_q];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        oh = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = onehot_bit(int'(owner_q), i);
        end
    end

    // First requester at or after ptr, wrapping.
    always_comb begin
        pick  = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_drv
        tristate_driver_w #(.W(W)) u_drv (
            .en    (en[g]),
            .din   (din[g*W +: W]),
            .bus_o (bus)
        );
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;

        can_load = !out_valid_q || out_ready;
        own_req  = req[owner_q];
        xfer     = (state_q == OWN) && own_req && can_load;
        en       = (state_q == OWN) ? oh : '0;
        gnt      = xfer ? oh : '0;

        if (xfer) begin
            dout_d      = bus;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    ptr_d   = IW'((int'(pick) + 1) % N);
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!own_req || (xfer && !hold)) begin
                    if (TURNAROUND > 0) begin
                        state_d = TURN;
                        cnt_d   = CNT_W'(TURNAROUND - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule
